// File: rtl/ipv4_hdr_chk.sv
// rtl/ipv4_hdr_chk.sv - receive-side IPv4 header checksum verifier (optional version check: IPV4_VER_CHK_EN)
module ipv4_hdr_chk #(
  parameter int ACC_W   = 21,
  parameter int IHL_MIN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  input  logic        hdr_sof,
  input  logic [31:0] hdr_word,
  output logic        in_ready,
  output logic        chk_done,
  output logic        chk_ok,
  output logic        err_ihl,
  output logic        err_ver,
  output logic [15:0] rx_chksum,
  output logic [15:0] fold_sum
);

  typedef enum logic [2:0] {IDLE, ACCUM, FOLD1, FOLD2, DONE} state_t;

  localparam logic [3:0] IHL_MIN_L = 4'(IHL_MIN);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         ihl_q, ihl_d;
  logic [15:0]        cap_chk_q, cap_chk_d;
  logic [15:0]        fold_q, fold_d;
  logic               perr_ihl_q, perr_ihl_d;
  logic               perr_ver_q, perr_ver_d;
  logic               in_ready_q, in_ready_d;
  logic               chk_done_q, chk_done_d;
  logic               chk_ok_q, chk_ok_d;
  logic               err_ihl_q, err_ihl_d;
  logic               err_ver_q, err_ver_d;
  logic [15:0]        rx_chksum_q, rx_chksum_d;
  logic [15:0]        fold_sum_q, fold_sum_d;

  logic               xfer;
  logic [ACC_W-1:0]   word_sum;
  logic [3:0]         first_ihl;
  logic               bad_ihl;
  logic               bad_ver;
  logic [3:0]         cnt_inc;
  logic [15:0]        fold2_sum;

  // Next-state and datapath: sof (re)starts a header, ACCUM sums halves, two folds, then publish results
  always_comb begin
    xfer      = hdr_valid && in_ready_q;
    word_sum  = {{(ACC_W-16){1'b0}}, hdr_word[31:16]} + {{(ACC_W-16){1'b0}}, hdr_word[15:0]};
    first_ihl = hdr_word[27:24];
    bad_ihl   = (first_ihl < IHL_MIN_L);
`ifdef IPV4_VER_CHK_EN
    bad_ver   = (hdr_word[31:28] != 4'd4);
`else
    bad_ver   = 1'b0;
`endif
    cnt_inc   = cnt_q + 4'd1;
    fold2_sum = acc_q[15:0] + {15'd0, acc_q[16]};

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ihl_d       = ihl_q;
    cap_chk_d   = cap_chk_q;
    fold_d      = fold_q;
    perr_ihl_d  = perr_ihl_q;
    perr_ver_d  = perr_ver_q;
    chk_done_d  = 1'b0;
    chk_ok_d    = chk_ok_q;
    err_ihl_d   = err_ihl_q;
    err_ver_d   = err_ver_q;
    rx_chksum_d = rx_chksum_q;
    fold_sum_d  = fold_sum_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (xfer && hdr_sof) begin
          // A sof in ACCUM silently drops the header in flight and starts over
          ihl_d      = first_ihl;
          acc_d      = word_sum;
          cnt_d      = 4'd1;
          cap_chk_d  = 16'd0;
          fold_d     = 16'd0;
          perr_ihl_d = bad_ihl;
          perr_ver_d = bad_ver;
          if (bad_ihl || bad_ver) begin
            state_d = DONE;
          end else if (first_ihl <= 4'd1) begin
            state_d = FOLD1;
          end else begin
            state_d = ACCUM;
          end
        end else if (xfer && (state_q == ACCUM)) begin
          acc_d = acc_q + word_sum;
          cnt_d = cnt_inc;
          if (cnt_q == 4'd2) begin
            cap_chk_d = hdr_word[15:0];
          end
          if (cnt_inc == ihl_q) begin
            state_d = FOLD1;
          end
        end
      end
      FOLD1: begin
        acc_d   = {{(ACC_W-16){1'b0}}, acc_q[15:0]} + {16'd0, acc_q[ACC_W-1:16]};
        state_d = FOLD2;
      end
      FOLD2: begin
        acc_d   = {{(ACC_W-16){1'b0}}, fold2_sum};
        fold_d  = fold2_sum;
        state_d = DONE;
      end
      DONE: begin
        chk_done_d  = 1'b1;
        chk_ok_d    = (fold_q == 16'hFFFF) && !perr_ihl_q && !perr_ver_q;
        err_ihl_d   = perr_ihl_q;
        err_ver_d   = perr_ver_q;
        rx_chksum_d = cap_chk_q;
        fold_sum_d  = fold_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

  // State and output registers; reset leaves only in_ready asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= 4'd0;
      ihl_q       <= 4'd0;
      cap_chk_q   <= 16'd0;
      fold_q      <= 16'd0;
      perr_ihl_q  <= 1'b0;
      perr_ver_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      chk_done_q  <= 1'b0;
      chk_ok_q    <= 1'b0;
      err_ihl_q   <= 1'b0;
      err_ver_q   <= 1'b0;
      rx_chksum_q <= 16'd0;
      fold_sum_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ihl_q       <= ihl_d;
      cap_chk_q   <= cap_chk_d;
      fold_q      <= fold_d;
      perr_ihl_q  <= perr_ihl_d;
      perr_ver_q  <= perr_ver_d;
      in_ready_q  <= in_ready_d;
      chk_done_q  <= chk_done_d;
      chk_ok_q    <= chk_ok_d;
      err_ihl_q   <= err_ihl_d;
      err_ver_q   <= err_ver_d;
      rx_chksum_q <= rx_chksum_d;
      fold_sum_q  <= fold_sum_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign chk_done  = chk_done_q;
  assign chk_ok    = chk_ok_q;
  assign err_ihl   = err_ihl_q;
  assign err_ver   = err_ver_q;
  assign rx_chksum = rx_chksum_q;
  assign fold_sum  = fold_sum_q;

endmodule
